// File: rtl/scan_sel_gen.sv
// ---------------------------------------------------------------------------
// scan_sel_gen
//
// Generates the digit-select index for a multiplexed 4-digit scan. Each
// enabled digit (mask bit set) is selected for div+1 cycles, optionally
// followed by blank_cycles of dead time. The selection walks upward through
// the enabled digits and wraps from 3 back to 0. frame_done pulses on the
// first dwell cycle of the digit that starts a new frame.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active high
//   en           : scan enable; low forces IDLE on the next cycle
//   div          : dwell length minus one (each digit lasts div+1 cycles)
//   mask         : bit i set means digit i takes part in the scan
//   blank_cycles : dead-time cycles between digits (0 = no gap)
//   sel          : registered digit index for the 2-to-4 decoder
//   sel_valid    : high when sel is a live selection
//   frame_done   : one-cycle pulse marking the start of a new frame
//   dbg_state    : current FSM state (0 IDLE, 1 DWELL, 2 BLANK)
//
// mask, div and blank_cycles are only looked at when leaving IDLE or at a
// dwell boundary; the values taken there govern the following dwell/blank.
// ---------------------------------------------------------------------------
module scan_sel_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       mask,
    input  logic [3:0]       blank_cycles,
    output logic [1:0]       sel,
    output logic             sel_valid,
    output logic             frame_done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // Next set mask bit strictly after cur, searching upward with wrap.
    // If cur is the only set bit the search lands back on cur.
    function automatic logic [1:0] f_next_idx(input logic [1:0] cur,
                                              input logic [3:0] m);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && m[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    state_t           r_state;
    logic [1:0]       r_sel;
    logic             r_sel_valid;
    logic             r_frame_done;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_bcnt;
    logic [1:0]       r_next;
    logic             r_wrap;

    state_t           w_state_nxt;
    logic [1:0]       w_sel_nxt;
    logic             w_valid_nxt;
    logic             w_fd_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [3:0]       w_bcnt_nxt;
    logic [1:0]       w_next_nxt;
    logic             w_wrap_nxt;

    logic [1:0]       w_cand;
    logic             w_cand_wrap;
    logic [1:0]       w_first;

    assign w_cand      = f_next_idx(r_sel, mask);
    assign w_cand_wrap = (w_cand <= r_sel);
    // Starting the search "after 3" yields the lowest set bit.
    assign w_first     = f_next_idx(2'd3, mask);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_valid_nxt = 1'b0;
        w_fd_nxt    = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_bcnt_nxt  = r_bcnt;
        w_next_nxt  = r_next;
        w_wrap_nxt  = r_wrap;

        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_bcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt  = '0;
                    w_bcnt_nxt = '0;
                    if (mask != 4'd0) begin
                        w_state_nxt = ST_DWELL;
                        w_sel_nxt   = w_first;
                        w_valid_nxt = 1'b1;
                        w_div_nxt   = div;
                    end
                end

                ST_DWELL: begin
                    if (r_cnt == r_div) begin
                        w_cnt_nxt = '0;
                        w_div_nxt = div;
                        if (mask == 4'd0) begin
                            w_state_nxt = ST_IDLE;
                        end else if (blank_cycles == 4'd0) begin
                            w_state_nxt = ST_DWELL;
                            w_sel_nxt   = w_cand;
                            w_valid_nxt = 1'b1;
                            w_fd_nxt    = w_cand_wrap;
                        end else begin
                            // Hold the old index through the gap; remember
                            // where to go and whether that starts a frame.
                            w_state_nxt = ST_BLANK;
                            w_bcnt_nxt  = blank_cycles - 4'd1;
                            w_next_nxt  = w_cand;
                            w_wrap_nxt  = w_cand_wrap;
                        end
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = r_cnt + DIV_W'(1);
                    end
                end

                ST_BLANK: begin
                    if (r_bcnt == 4'd0) begin
                        w_state_nxt = ST_DWELL;
                        w_sel_nxt   = r_next;
                        w_valid_nxt = 1'b1;
                        w_fd_nxt    = r_wrap;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_bcnt_nxt = r_bcnt - 4'd1;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_bcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= 2'd0;
            r_sel_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_cnt        <= '0;
            r_div        <= '0;
            r_bcnt       <= 4'd0;
            r_next       <= 2'd0;
            r_wrap       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_sel_valid  <= w_valid_nxt;
            r_frame_done <= w_fd_nxt;
            r_cnt        <= w_cnt_nxt;
            r_div        <= w_div_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_next       <= w_next_nxt;
            r_wrap       <= w_wrap_nxt;
        end
    end

    assign sel        = r_sel;
    assign sel_valid  = r_sel_valid;
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_scan_sel_gen.sv
// ---------------------------------------------------------------------------
// tb_scan_sel_gen
//
// Directed bench for scan_sel_gen. Inputs change 1 ns after a rising edge;
// outputs are examined at the same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
module tb_scan_sel_gen;

    localparam int DIV_W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DWELL = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    logic             clk;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic [3:0]       mask;
    logic [3:0]       blank_cycles;
    logic [1:0]       sel;
    logic             sel_valid;
    logic             frame_done;
    logic [1:0]       dbg_state;

    int checks;
    int errors;

    scan_sel_gen #(.DIV_W(DIV_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div          (div),
        .mask         (mask),
        .blank_cycles (blank_cycles),
        .sel          (sel),
        .sel_valid    (sel_valid),
        .frame_done   (frame_done),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] e_sel,
                           input logic e_valid, input logic e_fd);
        chk({tag, ".sel"},        16'(sel),        16'(e_sel));
        chk({tag, ".sel_valid"},  16'(sel_valid),  16'(e_valid));
        chk({tag, ".frame_done"}, 16'(frame_done), 16'(e_fd));
    endtask

    initial begin
        logic [1:0] exp_sel2 [7];
        logic       exp_v2   [7];
        logic       exp_fd2  [7];
        checks = 0;
        errors = 0;

        // ---- reset ----
        rst          = 1'b1;
        en           = 1'b0;
        div          = '0;
        mask         = 4'd0;
        blank_cycles = 4'd0;
        #2;
        chk_out("reset", 2'd0, 1'b0, 1'b0);
        chk("reset.state", 16'(dbg_state), 16'(S_IDLE));
        tick();
        tick();
        rst = 1'b0;

        // ---- mask==0 keeps IDLE even with en=1 ----
        en = 1'b1;
        tick();
        tick();
        chk_out("mask0_idle", 2'd0, 1'b0, 1'b0);
        chk("mask0_idle.state", 16'(dbg_state), 16'(S_IDLE));

        // ---- all four digits, div=2, no blanking ----
        mask = 4'b1111;
        div  = 16'd2;
        blank_cycles = 4'd0;
        for (int k = 0; k <= 12; k++) begin
            tick();
            chk_out($sformatf("full_scan[%0d]", k), 2'((k / 3) % 4), 1'b1, (k == 12));
        end
        tick();
        chk_out("full_scan[13]", 2'd0, 1'b1, 1'b0);

        en = 1'b0;
        tick();
        chk_out("en_drop", 2'd0, 1'b0, 1'b0);

        // ---- mask 1010, div=0, blank=2 ----
        mask = 4'b1010;
        div  = 16'd0;
        blank_cycles = 4'd2;
        en   = 1'b1;
        exp_sel2 = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd1};
        exp_v2   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_fd2  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            tick();
            chk_out($sformatf("blank_scan[%0d]", k), exp_sel2[k], exp_v2[k], exp_fd2[k]);
        end

        en = 1'b0;
        tick();
        chk_out("en_drop2", 2'd1, 1'b0, 1'b0);

        // ---- single digit 2, div=1: frame_done every 2 cycles ----
        mask = 4'b0100;
        div  = 16'd1;
        blank_cycles = 4'd0;
        en   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk_out($sformatf("single[%0d]", k), 2'd2, 1'b1, (k >= 2) && (k % 2 == 0));
        end

        en = 1'b0;
        tick();

        // ---- mask cleared (and div changed) mid-dwell on sel=1 ----
        mask = 4'b1111;
        div  = 16'd2;
        en   = 1'b1;
        tick(); tick(); tick();
        chk_out("mask_clr.sel0", 2'd0, 1'b1, 1'b0);
        tick();
        chk_out("mask_clr.sel1_first", 2'd1, 1'b1, 1'b0);
        mask = 4'b0000;
        div  = 16'd0;
        tick();
        chk_out("mask_clr.hold1", 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("mask_clr.hold2", 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("mask_clr.idle", 2'd1, 1'b0, 1'b0);
        chk("mask_clr.state", 16'(dbg_state), 16'(S_IDLE));
        tick();
        chk_out("mask_clr.stay", 2'd1, 1'b0, 1'b0);

        en = 1'b0;
        tick();

        // ---- drop en mid-BLANK, re-enable with mask 1000 ----
        mask = 4'b1111;
        div  = 16'd0;
        blank_cycles = 4'd3;
        en   = 1'b1;
        tick();
        chk_out("blank_drop.dwell", 2'd0, 1'b1, 1'b0);
        tick();
        chk("blank_drop.in_blank", 16'(dbg_state), 16'(S_BLANK));
        tick();
        chk_out("blank_drop.blank2", 2'd0, 1'b0, 1'b0);
        en   = 1'b0;
        mask = 4'b1000;
        tick();
        chk_out("blank_drop.idle", 2'd0, 1'b0, 1'b0);
        chk("blank_drop.state", 16'(dbg_state), 16'(S_IDLE));
        tick();
        chk("blank_drop.stay", 16'(dbg_state), 16'(S_IDLE));
        en = 1'b1;
        tick();
        chk_out("blank_drop.resume", 2'd3, 1'b1, 1'b0);
        chk("blank_drop.resume_state", 16'(dbg_state), 16'(S_DWELL));

        en = 1'b0;
        tick();

        // ---- asynchronous reset mid-dwell on sel=2 ----
        mask = 4'b0100;
        div  = 16'd5;
        blank_cycles = 4'd0;
        en   = 1'b1;
        tick();
        chk_out("async.pre", 2'd2, 1'b1, 1'b0);
        #2;
        rst  = 1'b1;
        mask = 4'b0110;
        #1;
        chk_out("async.during", 2'd0, 1'b0, 1'b0);
        chk("async.state", 16'(dbg_state), 16'(S_IDLE));
        tick();
        rst = 1'b0;
        tick();
        chk_out("async.restart", 2'd1, 1'b1, 1'b0);
        tick();
        chk_out("async.restart2", 2'd1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
